// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed 32x32 multiply (radix-2 Booth, 32 clocks)
// and signed restoring divide (32 clocks). Results go to HI/LO.
// Configuration macro MULT_DIV_DIV_EN: when defined, the divider datapath is
// built. When undefined, a divide request is rejected through DONE with
// div_zero set and HI/LO untouched.
//
// state | meaning
// IDLE  | waiting for start; operands captured on start
// MULT  | Booth iterations, then result write on the 33rd edge
// DIV   | divide iterations (or immediate reject), then result write
// DONE  | one-cycle done pulse, HI/LO write strobe
module mult_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        div_zero
);

    typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic [31:0] a_reg, b_reg;
    logic [32:0] work_hi;
    logic [31:0] work_lo;
    logic        booth_q;
    logic        dz_flag;
    logic        div_reject;
    logic        last_iter;
    logic        booth_bit;
    logic [32:0] booth_sum;

    assign last_iter = (cnt == 6'd32);
    // Multiplier bits are read straight from the captured operand, LSB first.
    assign booth_bit = b_reg[cnt[4:0]];

    // Booth add/subtract of the sign-extended multiplicand for this step
    always_comb begin
        booth_sum = work_hi;
        case ({booth_bit, booth_q})
            2'b01:   booth_sum = work_hi + {a_reg[31], a_reg};
            2'b10:   booth_sum = work_hi - {a_reg[31], a_reg};
            default: booth_sum = work_hi;
        endcase
    end

`ifdef MULT_DIV_DIV_EN
    logic [31:0] a_in_mag, b_mag, quo_signed, rem_signed;
    logic [32:0] div_shift, div_diff;
    logic        div_ge;

    // Magnitudes: 0x80000000 maps to itself, which is the correct unsigned value.
    assign a_in_mag   = a_in[31] ? -a_in : a_in;
    assign b_mag      = b_reg[31] ? -b_reg : b_reg;
    assign div_shift  = {work_hi[31:0], work_lo[31]};
    assign div_ge     = (div_shift >= {1'b0, b_mag});
    assign div_diff   = div_shift - {1'b0, b_mag};
    assign quo_signed = (a_reg[31] ^ b_reg[31]) ? -work_lo : work_lo;
    assign rem_signed = a_reg[31] ? -work_hi[31:0] : work_hi[31:0];
    assign div_reject = (b_reg == 32'd0);
`else
    assign div_reject = 1'b1;
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = op ? DIV : MULT;
            MULT: if (last_iter) state_nxt = DONE;
            DIV:  if (div_reject || last_iter) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs decoded from the state register
    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        div_zero = (state == DONE) && dz_flag;
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_reg   <= 32'd0;
            b_reg   <= 32'd0;
            cnt     <= 6'd0;
            work_hi <= 33'd0;
            work_lo <= 32'd0;
            booth_q <= 1'b0;
            dz_flag <= 1'b0;
            hi_out  <= 32'd0;
            lo_out  <= 32'd0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_reg   <= a_in;
                    b_reg   <= b_in;
                    cnt     <= 6'd0;
                    work_hi <= 33'd0;
                    booth_q <= 1'b0;
`ifdef MULT_DIV_DIV_EN
                    work_lo <= op ? a_in_mag : 32'd0;
`else
                    work_lo <= 32'd0;
`endif
                end
                MULT: if (last_iter) begin
                    hi_out  <= work_hi[31:0];
                    lo_out  <= work_lo;
                    dz_flag <= 1'b0;
                end else begin
                    work_hi <= {booth_sum[32], booth_sum[32:1]};
                    work_lo <= {booth_sum[0], work_lo[31:1]};
                    booth_q <= booth_bit;
                    cnt     <= cnt + 6'd1;
                end
                DIV: begin
`ifdef MULT_DIV_DIV_EN
                    if (div_reject) begin
                        dz_flag <= 1'b1;
                    end else if (last_iter) begin
                        hi_out  <= rem_signed;
                        lo_out  <= quo_signed;
                        dz_flag <= 1'b0;
                    end else begin
                        work_hi <= div_ge ? div_diff : div_shift;
                        work_lo <= {work_lo[30:0], div_ge};
                        cnt     <= cnt + 6'd1;
                    end
`else
                    dz_flag <= 1'b1;
`endif
                end
                DONE: dz_flag <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed and random operations checked against
// plain signed arithmetic. Follows MULT_DIV_DIV_EN the same way as the design.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a_in = 32'd0;
    logic [31:0] b_in = 32'd0;
    logic        busy, done, div_zero;
    logic [31:0] hi_out, lo_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    always #5 clock = ~clock;

    mult_div_unit dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .div_zero (div_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Issue one operation starting at the next rising edge and check it completely.
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b, input bit repulse);
        logic signed [63:0] sa, sb, prod, res_q, res_r;
        logic [31:0] old_hi, old_lo, new_hi, new_lo;
        logic        exp_dz;
        int          exp_lat, lat;
        old_hi = exp_hi;
        old_lo = exp_lo;
        new_hi = old_hi;
        new_lo = old_lo;
        sa = $signed(a);
        sb = $signed(b);
        exp_dz  = 1'b1;
        exp_lat = 1;
        if (!o) begin
            prod    = sa * sb;
            new_hi  = prod[63:32];
            new_lo  = prod[31:0];
            exp_dz  = 1'b0;
            exp_lat = 33;
        end else begin
`ifdef MULT_DIV_DIV_EN
            if (b != 32'd0) begin
                res_q   = sa / sb;
                res_r   = sa % sb;
                new_lo  = res_q[31:0];
                new_hi  = res_r[31:0];
                exp_dz  = 1'b0;
                exp_lat = 33;
            end
`endif
        end

        start = 1'b1; op = o; a_in = a; b_in = b;
        @(posedge clock); #1;
        start = 1'b0;
        a_in = $urandom;
        b_in = $urandom;
        check("busy_after_start", {63'd0, busy}, 64'd1);

        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (repulse && k == 10) begin
                start = 1'b1;
                op = ~o;
            end
            @(posedge clock); #1;
            start = 1'b0;
            if (k == 16 && exp_lat > 16)
                check("hold_while_busy", {hi_out, lo_out}, {old_hi, old_lo});
            if (done) begin
                lat = k;
                break;
            end
        end
        check("done_latency", 64'(lat), 64'(exp_lat));
        check("hi_out", {32'd0, hi_out}, {32'd0, new_hi});
        check("lo_out", {32'd0, lo_out}, {32'd0, new_lo});
        check("div_zero", {63'd0, div_zero}, {63'd0, exp_dz});
        @(posedge clock); #1;
        check("idle_after_done", {61'd0, busy, done, div_zero}, 64'd0);
        exp_hi = new_hi;
        exp_lo = new_lo;
    endtask

    initial begin
        int   ndone;
        logic o;
        logic [31:0] a, b;

        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
        check("reset_hilo", {hi_out, lo_out}, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // First start right after release, then the directed vectors
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0);
        run_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(1'b1, 32'd100, 32'd0, 1'b0);
        run_op(1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(1'b0, 32'h0001_0003, 32'h0002_0005, 1'b1);

        // Abort: re-pulse start at edge 10, reset low just after edge 20
        start = 1'b1; op = 1'b0; a_in = 32'h1234_5678; b_in = 32'd3;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        start = 1'b1; a_in = 32'h0BAD_0BAD; b_in = 32'd5;
        @(posedge clock); #1;
        start = 1'b0;
        check("busy_after_repulse", {63'd0, busy}, 64'd1);
        repeat (10) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("abort_flags", {61'd0, busy, done, div_zero}, 64'd0);
        check("abort_hilo", {hi_out, lo_out}, 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (done) ndone++;
        end
        check("no_done_after_abort", 64'(ndone), 64'd0);

        run_op(1'b0, 32'hFFFF_FF00, 32'd300, 1'b0);

        // Random operations
        for (int i = 0; i < 24; i++) begin
            o = 1'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_op(o, a, b, (i % 6) == 5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports as listed below.
REQ-002 SHALL provide port: clock  input  1  system clock, rising-edge active.
REQ-003 SHALL provide port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL provide port: op  input  1  operation select: 0 = signed mult, 1 = signed div.
REQ-006 SHALL provide port: a_in  input  32  multiplicand/dividend, driven by MDSrcA.
REQ-007 SHALL provide port: b_in  input  32  multiplier/divisor, driven by MDSrcB.
REQ-008 SHALL provide port: busy  output  1  high in every state except IDLE.
REQ-009 SHALL provide port: done  output  1  single-cycle pulse; HI/LO write strobe for the control unit.
REQ-010 SHALL provide port: hi_out  output  32  product high word or remainder; feeds HI register.
REQ-011 SHALL provide port: lo_out  output  32  product low word or quotient; feeds LO register.
REQ-012 SHALL provide port: div_zero  output  1  divide-by-zero flag, valid with done.

Function
REQ-013 SHALL implement FSM states IDLE, MULT, DIV, DONE; all outputs registered.
REQ-014 IDLE: start=1 at an edge SHALL capture a_in, b_in, op into internal registers, clear the 6-bit iteration counter, go to MULT (op=0) or DIV (op=1).
REQ-015 start SHALL be ignored in MULT, DIV and DONE; operands SHALL not be re-sampled while busy.
REQ-016 MULT: signed radix-2 Booth, one iteration per clock, 32 iterations; 64-bit product, HI = bits 63:32, LO = bits 31:0.
REQ-017 DIV: restoring division on magnitudes, one quotient bit per clock, 32 iterations; signs then applied: quotient truncates toward zero, remainder takes dividend sign; LO = quotient, HI = remainder.
REQ-018 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000, div_zero=0.
REQ-019 Latency: start sampled at edge 0; iterations at edges 1..32; DONE entered at edge 33 with hi_out/lo_out updated and done=1; IDLE at edge 34.
REQ-020 DIV with b_in=0 SHALL go from IDLE to DONE at edge 1; done=1 and div_zero=1 for that cycle; hi_out/lo_out SHALL keep previous values.
REQ-021 done and div_zero SHALL be high only in DONE; div_zero SHALL be 0 for every mult.
REQ-022 hi_out/lo_out SHALL hold the last result until the next DONE, including while busy.

Reset
REQ-023 reset low SHALL force IDLE immediately, independent of clock; hi_out, lo_out, counter and captured operands = 0; busy, done, div_zero = 0.
REQ-024 reset asserted mid-operation SHALL abort it; no done pulse SHALL follow release.
REQ-025 After reset release, the first start SHALL be accepted at the first rising edge with reset high.

Configuration
REQ-026 Macro MULT_DIV_DIV_EN defined: divider datapath and DIV state present, behaviour per REQ-017..REQ-020.
REQ-027 MULT_DIV_DIV_EN undefined: no divider logic; start with op=1 SHALL go to DONE at edge 1 with done=1, div_zero=1, hi_out/lo_out unchanged; mult unaffected.

Verification
REQ-028 mult 7 x 0xFFFFFFFD -> done at edge 33, hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB, div_zero=0.
REQ-029 mult 0x7FFFFFFF x 0x7FFFFFFF -> hi_out=0x3FFFFFFF, lo_out=0x00000001.
REQ-030 div 0xFFFFFFF9 / 2 -> done at edge 33, lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF.
REQ-031 div 100 / 0 after prior result -> done and div_zero high at edge 1, hi_out/lo_out unchanged; repeat with MULT_DIV_DIV_EN undefined for op=1, any b_in.
REQ-032 mult started, start re-pulsed at edge 10 with new operands, reset low at edge 20 -> re-pulse ignored, all outputs 0 immediately, no done; next start completes normally.
REQ-033 div 0x80000000 / 0xFFFFFFFF -> lo_out=0x80000000, hi_out=0, div_zero=0.
